// File: rtl/f2s_pkg.sv
// Shared types and defaults for the fast-to-slow burst pacer.
package f2s_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_GAP        = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/f2s_sfifo.sv
// Single-clock circular FIFO; head_o shows the oldest word whenever not empty.
module f2s_sfifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int AW         = $clog2(DEPTH),
  localparam int LW         = AW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [LW-1:0]         level_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;

  // Storage is not reset: only words between the pointers are ever observed.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/f2s_burst_pacer.sv
// Buffers bursty words and re-issues them as single-cycle valid_out pulses
// spaced GAP cycles apart so a slower capture domain never misses one.
module f2s_burst_pacer
  import f2s_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int GAP        = DEF_GAP,
  localparam int LW         = $clog2(DEPTH) + 1,
  localparam int CW         = $clog2(GAP + 1)
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid_out,
  output logic [LW-1:0]         level,
  output logic                  busy,
  output state_t                dbg_state_o
);

  // Handshake: a word transfers on any clka edge where s_valid and s_ready are
  // both high; s_ready depends only on registered occupancy, never on s_valid.

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  vout_q, vout_d;

  logic                  push, pop, full, empty;
  logic [DATA_WIDTH-1:0] head;

  assign s_ready = !rst && !full;
  assign push    = s_valid && s_ready;
  assign pop     = (state_q == ST_IDLE) && !empty;

  f2s_sfifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_i   (clka),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (s_data),
    .pop_i   (pop),
    .head_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          dout_d  = head;
          vout_d  = 1'b1;
          cnt_d   = CW'(GAP - 1);
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        cnt_d   = cnt_q - CW'(1);
        state_d = (GAP == 2) ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        // Leaving on cnt==1 makes the next IDLE pop land exactly GAP edges later.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
    end
  end

  assign dout        = dout_q;
  assign valid_out   = vout_q;
  assign busy        = (state_q != ST_IDLE) || (level != '0);
  assign dbg_state_o = state_q;

endmodule
